// File: rtl/spart_rx.sv
// SPART receive half: 8N1 deserialiser driven by the shared oversampling enable.
// Define SPART_RX_MAJORITY_EN for 2-of-3 majority voting at every sample point.
module spart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rxd,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

`ifdef SPART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  // Decision points: the start bit is judged at its centre (+1 with voting); every
  // later bit is judged OVERSAMPLE enables after the previous decision.
  localparam logic [CW-1:0] START_DEC = CW'(OVERSAMPLE / 2 - 1 + MAJ);
  localparam logic [CW-1:0] BIT_DEC   = CW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_en_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_armed;
  logic [CW-1:0]          w_dec_pt;
  logic                   w_samp;
  logic                   w_bit;
  logic                   w_rd;
  logic                   w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
  end

  assign w_rx_s   = r_sync[SYNC_STAGES-1];
  assign w_dec_pt = (r_state == S_START) ? START_DEC : BIT_DEC;
  assign w_samp   = enable && (r_state != S_IDLE) && (r_en_cnt == w_dec_pt);
  assign w_rd     = iocs && iorw && (ioaddr == 2'b00);
  assign w_done   = w_samp && (r_state == S_STOP);

`ifdef SPART_RX_MAJORITY_EN
  logic [1:0] r_maj;

  // The two earlier votes are captured on the enables just before the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_maj <= '1;
    end else if (enable && (r_state != S_IDLE)) begin
      if (r_en_cnt == w_dec_pt - CW'(2)) r_maj[0] <= w_rx_s;
      if (r_en_cnt == w_dec_pt - CW'(1)) r_maj[1] <= w_rx_s;
    end
  end

  assign w_bit = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rx_s) | (r_maj[1] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_en_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_armed   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_en_cnt <= '0;
          // A start needs a high level seen in IDLE first, so a stuck-low line
          // yields a single frame rather than a stream of them.
          if (w_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_samp) begin
            r_en_cnt <= '0;
            if (!w_bit) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (enable) begin
            r_en_cnt <= r_en_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_samp) begin
            r_en_cnt  <= '0;
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
          end else if (enable) begin
            r_en_cnt <= r_en_cnt + CW'(1);
          end
        end
        default: begin
          if (w_samp) begin
            r_en_cnt <= '0;
            r_state  <= S_IDLE;
          end else if (enable) begin
            r_en_cnt <= r_en_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // A completing frame takes priority over a coincident read; the read then only
  // suppresses the overrun it would otherwise have caused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (w_done) begin
      rx_data     <= r_shift;
      rda         <= 1'b1;
      framing_err <= ~w_bit;
      overrun     <= w_rd ? 1'b0 : (overrun | rda);
    end else if (w_rd) begin
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: frame-level reference model compared on every settled cycle,
// with directed scenarios followed by randomized frames, gaps, reads and glitches.
module tb_spart_rx;

  localparam int OV = 16;
  localparam int EP = 2;        // clocks per enable pulse
  localparam int T  = OV * EP;  // clocks per bit
  localparam int FT = 10 * T;   // clocks per frame

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rxd = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  spart_rx #(.OVERSAMPLE(OV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rxd(rxd),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .rx_data(rx_data), .rda(rda), .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = -1;
  bit dontcare = 1'b0;

  // Frame-level model of the register file
  logic [7:0] m_data = 8'h00;
  bit m_rda = 1'b0, m_fe = 1'b0, m_ovr = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!dontcare) begin
      chk("rx_data", rx_data, m_data);
      chk("rda", {7'b0, rda}, {7'b0, m_rda});
      chk("framing_err", {7'b0, framing_err}, {7'b0, m_fe});
      chk("overrun", {7'b0, overrun}, {7'b0, m_ovr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    enable = (cyc % EP == 0);
    cyc++;
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop, input bit rd_coinc);
    m_data = b;
    m_ovr  = rd_coinc ? 1'b0 : (m_ovr | m_rda);
    m_rda  = 1'b1;
    m_fe   = ~stop;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic rd(input logic [1:0] addr, input bit rw);
    tick();
    iocs = 1'b1; iorw = rw; ioaddr = addr;
    tick();
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    if (rw && addr == 2'b00) begin
      m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    end
  endtask

  task automatic glitch();
    tick();
    rxd = 1'b0;
    repeat (4 * EP) tick();
    rxd = 1'b1;
    repeat (T) tick();
  endtask

  // rd_off/glitch_at/abort_at are clock offsets from the start edge, -1 = unused.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int rd_off,
                            input int glitch_at, input int abort_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    while (cyc % EP != 0) tick();
    for (int f = 0; f < FT; f++) begin
      tick();
      if (f == abort_at) begin
        rst_n = 1'b0;
        model_reset();
        rxd = 1'b1;
        iocs = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
      rxd = bits[f / T];
      if (glitch_at >= 0 && f >= glitch_at && f < glitch_at + EP) rxd = ~rxd;
      dontcare = (f >= 9 * T);
      iocs = (f == rd_off); iorw = 1'b1; ioaddr = 2'b00;
      if (lat < 0 && f >= 9 * T && rda === 1'b1) lat = f;
    end
    iocs = 1'b0; iorw = 1'b0;
    model_frame(b, stop, rd_off >= 0);
    dontcare = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    bit         rs;
    repeat (3) tick();
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rda", {7'b0, rda}, 8'h00);
    rst_n = 1'b1;
    idle(T);

    // Single frame 0x5A, then a data read
    send_frame(8'h5A, 1'b1, -1, -1, -1);
    idle(T);
    chk("t1_model_data", m_data, 8'h5A);
    chk("t1_rx_data", rx_data, 8'h5A);
    chk("t1_rda", {7'b0, rda}, 8'h01);
    chk("t1_fe_ovr", {6'b0, framing_err, overrun}, 8'h00);
    chk("t1_lat_found", {7'b0, lat >= 0}, 8'h01);
    chk("t1_latency_range", {7'b0, (lat >= 9 * T + T / 2) && (lat <= 9 * T + T / 2 + 8)}, 8'h01);
    if (lat < 0) lat = 9 * T + T / 2 + 3;
    rd(2'b01, 1'b1);
    rd(2'b00, 1'b0);
    chk("t1_rda_kept_other_addr", {7'b0, rda}, 8'h01);
    rd(2'b00, 1'b1);
    chk("t1_rda_clr", {7'b0, rda}, 8'h00);

    // Glitch rejection, then a valid frame
    glitch();
    chk("t2_glitch_rda", {7'b0, rda}, 8'h00);
    send_frame(8'hC3, 1'b1, -1, -1, -1);
    idle(T);
    chk("t2_rx_data", rx_data, 8'hC3);
    rd(2'b00, 1'b1);

    // Framing error, line then held low
    send_frame(8'h81, 1'b0, -1, -1, -1);
    repeat (2 * FT) tick();
    chk("t3_rx_data", rx_data, 8'h81);
    chk("t3_rda_fe", {6'b0, rda, framing_err}, 8'h03);
    rd(2'b00, 1'b1);
    repeat (FT) tick();
    chk("t3_no_second_rda", {7'b0, rda}, 8'h00);
    idle(T);

    // Back-to-back with overrun
    send_frame(8'h11, 1'b1, -1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1, -1);
    idle(T);
    chk("t4_rx_data", rx_data, 8'h22);
    chk("t4_rda_fe_ovr", {5'b0, rda, framing_err, overrun}, 8'h05);
    rd(2'b00, 1'b1);
    chk("t4_cleared", {5'b0, rda, framing_err, overrun}, 8'h00);

    // Read coincident with completion
    send_frame(8'h11, 1'b1, -1, -1, -1);
    idle(T);
    send_frame(8'h33, 1'b1, lat - 1, -1, -1);
    idle(T);
    chk("t5_rx_data", rx_data, 8'h33);
    chk("t5_rda_ovr", {6'b0, rda, overrun}, 8'h02);
    rd(2'b00, 1'b1);

    // Reset mid-frame, then a clean frame
    send_frame(8'hFF, 1'b1, -1, -1, 5 * T + 4);
    chk("t6_reset_outputs", rx_data | {4'b0, rda, framing_err, overrun, 1'b0}, 8'h00);
    idle(FT);
    send_frame(8'h0F, 1'b1, -1, -1, -1);
    idle(T);
    chk("t6_rx_data", rx_data, 8'h0F);
    rd(2'b00, 1'b1);

`ifdef SPART_RX_MAJORITY_EN
    send_frame(8'h0F, 1'b1, -1, 3 * T + T / 2 - 1, -1);
    idle(T);
    chk("t7_majority_data", rx_data, 8'h0F);
    rd(2'b00, 1'b1);
`endif

    // Randomized frames, gaps, reads and glitches
    for (int i = 0; i < 30; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      send_frame(rb, rs, -1, -1, -1);
      if (!rs) idle(T);
      case ($urandom_range(0, 3))
        0: ;
        1: idle(int'($urandom_range(1, T)));
        2: rd(2'b00, 1'b1);
        default: begin
          rd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 1) == 1) glitch();
        end
      endcase
    end
    idle(T);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive half of the SPART serial port.
- Deserialises 8N1 frames (start 0, 8 data bits LSB first, stop 1) from the asynchronous rxd line, using the shared 16x baud enable from the baud generator.
- Presents the received byte and status to the processor bus through the same iocs/iorw/ioaddr bus interface as the transmit half.
- Sits beside the transmitter inside the SPART top, sharing clk, rst_n and enable.

Parameters:
- OVERSAMPLE, 16: enable pulses per bit time. Must be even and at least 4.
- SYNC_STAGES, 2: flip-flop stages on rxd before any use. Minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- enable  input  1  one-clk pulse at OVERSAMPLE x baud rate
- rxd  input  1  serial receive line, asynchronous, idles high
- iocs  input  1  bus chip select
- iorw  input  1  bus direction; 1 = read
- ioaddr  input  2  bus register address; 2'b00 = data register
- rx_data  output  8  last completed byte
- rda  output  1  receive data available
- framing_err  output  1  last completed byte had stop bit = 0
- overrun  output  1  a byte completed while rda was already set

Behaviour:
- Reset values:
  - rx_data = 8'h00; rda = 0; framing_err = 0; overrun = 0.
  - Synchroniser stages = 1; state = IDLE; en_count = 0; bit_cnt = 0.
- Synchroniser: rxd passes through SYNC_STAGES flops; all logic below uses only the synchronised value rx_s.
- en_count: width $clog2(OVERSAMPLE)+1. It increments only on enable, is cleared at every state transition, and never wraps within a state.
- States and transitions:
  - IDLE: en_count held at 0. rx_s == 0 -> START.
  - START: when en_count reaches OVERSAMPLE/2-1 on an enable (the mid-start-bit sample), sample the line.
    - Sample 0 -> DATA, bit_cnt = 0.
    - Sample 1 -> IDLE (glitch rejected; no flag set).
  - DATA: sample on every OVERSAMPLE-th enable after entry, i.e. mid-bit.
    - Shift the sample into shift_reg[7] and shift right, so data arrives LSB first; bit_cnt increments.
    - After the 8th sample -> STOP.
  - STOP: sample mid-stop-bit after OVERSAMPLE enables, then go to IDLE in the same cycle.
    - Load rx_data with shift_reg.
    - Set rda = 1 and framing_err = ~sample.
    - Set overrun = 1 if rda was already 1 at that moment; otherwise overrun keeps its value.
    - Because the block returns to IDLE at mid-stop-bit, a start bit immediately following the stop bit is caught.
- Latency: rda rises the clk edge after the stop-bit sample. That is 9.5 bit times plus SYNC_STAGES clks after the rxd falling edge.
- Bus read: iocs && iorw && ioaddr == 2'b00 is a data read.
  - rx_data is driven continuously, so the read needs no wait state.
  - On the next edge the read clears rda, framing_err and overrun.
  - Reads at other addresses, or with iorw = 0, have no effect on the receiver.
- Simultaneous data read and frame completion in the same cycle:
  - The new byte wins: rda stays 1 and rx_data takes the new byte.
  - overrun is not set.
  - framing_err reflects the new frame.
- enable with no frame in progress has no effect. rxd held low indefinitely produces one frame with framing_err = 1, then START is re-entered only after rx_s returns to 1 and falls again. A falling-edge-armed flag in IDLE implements this.
- rst_n asserted mid-frame aborts the frame immediately and returns all outputs to reset values. The partial byte is discarded.

Optional Feature:
- Macro: SPART_RX_MAJORITY_EN.
- Defined: each sample point (start, data, stop) takes rx_s at en_count = centre-1, centre and centre+1 and uses the 2-of-3 majority. The decision is made on the centre+1 enable, so all later sample points shift by one enable and latency grows by 1/OVERSAMPLE bit.
- Undefined: single sample at the centre enable, exactly as described above.

Test Plan:
- Single frame, OVERSAMPLE=16, rxd = 0x5A sent LSB first with stop = 1 -> rda = 1, rx_data = 8'h5A, framing_err = 0, overrun = 0. Then a read at ioaddr 00 -> rda = 0 next clk.
- Glitch: rxd low for 4 enables, then high -> state returns to IDLE, rda stays 0. A following valid 0xC3 frame is received correctly.
- Framing error: frame 0x81 with stop bit = 0 -> rx_data = 8'h81, rda = 1, framing_err = 1. rxd then held low -> no second rda until rxd goes high and falls again.
- Overrun and back-to-back: frames 0x11 then 0x22 with zero idle between them and no read -> rx_data = 8'h22, rda = 1, overrun = 1. A read clears all three flags.
- Read coincident with completion of 0x33 while rda = 1 from 0x11 -> rda stays 1, rx_data = 8'h33, overrun = 0.
- rst_n pulsed after the 4th data bit of 0xFF -> all outputs 0. A subsequent frame 0x0F is received cleanly. With SPART_RX_MAJORITY_EN, a one-enable-wide inverted glitch at a data-bit centre does not corrupt 0x0F.
